dcache_mem_req_arbiter: RTL and testbench

- Parametrised successor of the DCache MSHR-to-memory request arbiter/multiplexer pair.
- Arbitrates NUM_REQ miss-handler requesters onto one memory request port.
- Round-robin fairness, with write-first priority while the DCache is flushing.
- Holds the selected request stable until memory accepts it, and throttles reads against an outstanding-read limit.
- Forwards the memory-assigned serial back to the winning requester.

---
 rtl/dcache_mem_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_dcache_mem_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_req_arbiter.sv
// Round-robin arbiter that funnels DCache miss-handler requests onto one memory port,
// holding each request until memory accepts it and throttling reads on outstanding count.
module dcache_mem_req_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_W     = 32,
    parameter  int LINE_W     = 128,
    parameter  int SERIAL_W   = 4,
    parameter  int MAX_RD_OUT = 4,
    localparam int CNT_W      = $clog2(MAX_RD_OUT + 1),
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           reqIsWrite,
    input  logic [NUM_REQ*ADDR_W-1:0]    reqAddr,
    input  logic [NUM_REQ*LINE_W-1:0]    reqData,
    input  logic                         dcFlushing,
    output logic [NUM_REQ-1:0]           grant,
    output logic [SERIAL_W-1:0]          grantSerial,
    output logic                         memValid,
    output logic                         memWE,
    output logic [ADDR_W-1:0]            memAddr,
    output logic [LINE_W-1:0]            memData,
    input  logic                         memReqAck,
    input  logic [SERIAL_W-1:0]          memSerial,
    input  logic [SERIAL_W-1:0]          memWSerial,
    input  logic                         rdRspValid,
    output logic [CNT_W-1:0]             rdOutstanding,
    output logic                         rdFull
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [IDX_W-1:0]    r_rrPtr;
    logic [IDX_W-1:0]    r_sel;
    logic                r_memWE;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [LINE_W-1:0]   r_memData;
    logic [CNT_W-1:0]    r_rdCnt;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_eligWrite;
    logic [NUM_REQ-1:0]  w_cand;
    logic                w_found;
    logic [IDX_W-1:0]    w_pick;
    int                  w_scanIdx;
    logic                w_ackNow;
    logic                w_rdInc;
    logic [IDX_W-1:0]    w_nextPtr;

    assign rdFull        = (r_rdCnt == CNT_W'(MAX_RD_OUT));
    assign rdOutstanding = r_rdCnt;
    assign memValid      = (r_state == HOLD);
    assign memWE         = r_memWE;
    assign memAddr       = r_memAddr;
    assign memData       = r_memData;

    // During a flush only writes compete, unless no write is eligible at all.
    assign w_eligible  = req & (reqIsWrite | {NUM_REQ{~rdFull}});
    assign w_eligWrite = w_eligible & reqIsWrite;
    assign w_cand      = (dcFlushing && (|w_eligWrite)) ? w_eligWrite : w_eligible;

    // Scan from the highest offset down so the candidate nearest rrPtr is assigned last.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_scanIdx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scanIdx = int'(r_rrPtr) + k;
            if (w_scanIdx >= NUM_REQ) begin
                w_scanIdx = w_scanIdx - NUM_REQ;
            end
            if (w_cand[w_scanIdx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_scanIdx);
            end
        end
    end

    // A reset arriving together with an ack swallows the ack.
    assign w_ackNow  = (r_state == HOLD) && memReqAck && !rst;
    assign w_rdInc   = w_ackNow && !r_memWE;
    assign w_nextPtr = (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_nextState = r_state;
        grant       = '0;
        grantSerial = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_ackNow) begin
                    grant[r_sel] = 1'b1;
                    grantSerial  = r_memWE ? memWSerial : memSerial;
                    w_nextState  = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_sel     <= '0;
            r_memWE   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
            r_rdCnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_found) begin
                r_sel     <= w_pick;
                r_memWE   <= reqIsWrite[w_pick];
                r_memAddr <= reqAddr[w_pick*ADDR_W +: ADDR_W];
                r_memData <= reqData[w_pick*LINE_W +: LINE_W];
            end
            if (w_ackNow) begin
                r_rrPtr <= w_nextPtr;
            end
            if (w_rdInc && !rdRspValid) begin
                r_rdCnt <= r_rdCnt + 1'b1;
            end else if (!w_rdInc && rdRspValid && r_rdCnt != '0) begin
                r_rdCnt <= r_rdCnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_mem_req_arbiter.sv
// Bench for dcache_mem_req_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_dcache_mem_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int SW = 4;
    localparam int MX = 2;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   reqIsWrite;
    logic [NR*AW-1:0] reqAddr;
    logic [NR*LW-1:0] reqData;
    logic            dcFlushing;
    logic [NR-1:0]   grant;
    logic [SW-1:0]   grantSerial;
    logic            memValid;
    logic            memWE;
    logic [AW-1:0]   memAddr;
    logic [LW-1:0]   memData;
    logic            memReqAck;
    logic [SW-1:0]   memSerial;
    logic [SW-1:0]   memWSerial;
    logic            rdRspValid;
    logic [1:0]      rdOutstanding;
    logic            rdFull;

    int passCount = 0;
    int checkCount = 0;

    dcache_mem_req_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .LINE_W(LW), .SERIAL_W(SW), .MAX_RD_OUT(MX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .reqIsWrite(reqIsWrite), .reqAddr(reqAddr),
        .reqData(reqData), .dcFlushing(dcFlushing), .grant(grant), .grantSerial(grantSerial),
        .memValid(memValid), .memWE(memWE), .memAddr(memAddr), .memData(memData),
        .memReqAck(memReqAck), .memSerial(memSerial), .memWSerial(memWSerial),
        .rdRspValid(rdRspValid), .rdOutstanding(rdOutstanding), .rdFull(rdFull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clearInputs();
        req = '0; reqIsWrite = '0; reqAddr = '0; reqData = '0;
        dcFlushing = 1'b0; memReqAck = 1'b0; memSerial = '0; memWSerial = '0; rdRspValid = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        req = 4'b1111; memReqAck = 1'b1; reqAddr = {4{32'hDEAD_BEEF}};
        repeat (3) @(negedge clk);
        #1;
        checkCount++; if (memValid !== 1'b0) $display("[TB] FAIL reset_memValid: got %b expected 0", memValid); else passCount++;
        checkCount++; if (memWE !== 1'b0) $display("[TB] FAIL reset_memWE: got %b expected 0", memWE); else passCount++;
        checkCount++; if (memAddr !== '0) $display("[TB] FAIL reset_memAddr: got %h expected 0", memAddr); else passCount++;
        checkCount++; if (memData !== '0) $display("[TB] FAIL reset_memData: got %h expected 0", memData); else passCount++;
        checkCount++; if (grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b expected 0000", grant); else passCount++;
        checkCount++; if (grantSerial !== 4'h0) $display("[TB] FAIL reset_grantSerial: got %h expected 0", grantSerial); else passCount++;
        checkCount++; if (rdOutstanding !== 2'd0) $display("[TB] FAIL reset_rdOutstanding: got %0d expected 0", rdOutstanding); else passCount++;
        checkCount++; if (rdFull !== 1'b0) $display("[TB] FAIL reset_rdFull: got %b expected 0", rdFull); else passCount++;
        rst = 1'b0;
        clearInputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] expG;
        doReset();
        for (int i = 0; i < NR; i++) reqAddr[i*AW +: AW] = 32'h100 * (i + 1);
        req = 4'b1111; reqIsWrite = 4'b0000; memReqAck = 1'b1; rdRspValid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            memSerial = 4'(j);
            #1;
            expG = (j % 2 == 1) ? (4'b0001 << ((j / 2) % 4)) : 4'b0000;
            checkCount++; if (grant !== expG) $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", j, grant, expG); else passCount++;
            if (j % 2 == 1) begin
                checkCount++; if (memAddr !== 32'h100 * ((j / 2) % 4 + 1)) $display("[TB] FAIL rr_addr[%0d]: got %h expected %h", j, memAddr, 32'h100 * ((j / 2) % 4 + 1)); else passCount++;
                checkCount++; if (grantSerial !== 4'(j)) $display("[TB] FAIL rr_serial[%0d]: got %h expected %h", j, grantSerial, 4'(j)); else passCount++;
            end
        end
        clearInputs();
    endtask

    task automatic test_hold_stall();
        doReset();
        req = 4'b0100; reqIsWrite = 4'b0100;
        reqAddr[2*AW +: AW] = 32'h1000;
        reqData[2*LW +: LW] = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
        #1;
        checkCount++; if (memValid !== 1'b0) $display("[TB] FAIL hold_idle_valid: got %b expected 0", memValid); else passCount++;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #1;
            checkCount++; if (memValid !== 1'b1 || memWE !== 1'b1 || memAddr !== 32'h1000)
                $display("[TB] FAIL hold_stable[%0d]: got v=%b we=%b a=%h expected v=1 we=1 a=00001000", s, memValid, memWE, memAddr);
            else passCount++;
            checkCount++; if (grant !== 4'b0000) $display("[TB] FAIL hold_nogrant[%0d]: got %b expected 0000", s, grant); else passCount++;
        end
        checkCount++; if (memData !== 128'hCAFE_0000_1111_2222_3333_4444_5555_6666) $display("[TB] FAIL hold_data: got %h", memData); else passCount++;
        @(negedge clk);
        memReqAck = 1'b1; memWSerial = 4'd7; memSerial = 4'd3;
        #1;
        checkCount++; if (grant !== 4'b0100) $display("[TB] FAIL hold_grant: got %b expected 0100", grant); else passCount++;
        checkCount++; if (grantSerial !== 4'd7) $display("[TB] FAIL hold_serial: got %0d expected 7", grantSerial); else passCount++;
        @(negedge clk);
        req = '0; memReqAck = 1'b0;
        #1;
        checkCount++; if (memValid !== 1'b0 || grant !== 4'b0000) $display("[TB] FAIL hold_release: got v=%b g=%b expected v=0 g=0000", memValid, grant); else passCount++;
        clearInputs();
    endtask

    task automatic test_read_throttle();
        doReset();
        for (int i = 0; i < NR; i++) reqAddr[i*AW +: AW] = 32'h2000 + i;
        req = 4'b0011; reqIsWrite = 4'b0000; memReqAck = 1'b1;
        #1;
        checkCount++; if (rdOutstanding !== 2'd0) $display("[TB] FAIL thr_c0_cnt: got %0d expected 0", rdOutstanding); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b0001) $display("[TB] FAIL thr_c1_grant: got %b expected 0001", grant); else passCount++;
        @(negedge clk); req = 4'b0010; #1;
        checkCount++; if (rdOutstanding !== 2'd1 || rdFull !== 1'b0) $display("[TB] FAIL thr_c2_cnt: got %0d/%b expected 1/0", rdOutstanding, rdFull); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b0010) $display("[TB] FAIL thr_c3_grant: got %b expected 0010", grant); else passCount++;
        @(negedge clk); req = 4'b1100; reqIsWrite = 4'b1000; #1;
        checkCount++; if (rdOutstanding !== 2'd2 || rdFull !== 1'b1) $display("[TB] FAIL thr_c4_full: got %0d/%b expected 2/1", rdOutstanding, rdFull); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b1000 || memWE !== 1'b1) $display("[TB] FAIL thr_c5_write: got g=%b we=%b expected g=1000 we=1", grant, memWE); else passCount++;
        @(negedge clk); req = 4'b0100; reqIsWrite = 4'b0000; #1;
        checkCount++; if (rdOutstanding !== 2'd2) $display("[TB] FAIL thr_c6_cnt: got %0d expected 2", rdOutstanding); else passCount++;
        @(negedge clk); rdRspValid = 1'b1; #1;
        checkCount++; if (memValid !== 1'b0) $display("[TB] FAIL thr_c7_blocked: got %b expected 0", memValid); else passCount++;
        @(negedge clk); rdRspValid = 1'b0; #1;
        checkCount++; if (rdOutstanding !== 2'd1 || rdFull !== 1'b0) $display("[TB] FAIL thr_c8_cnt: got %0d/%b expected 1/0", rdOutstanding, rdFull); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b0100 || memAddr !== 32'h2002) $display("[TB] FAIL thr_c9_read: got g=%b a=%h expected g=0100 a=00002002", grant, memAddr); else passCount++;
        @(negedge clk); req = '0; #1;
        checkCount++; if (rdOutstanding !== 2'd2) $display("[TB] FAIL thr_c10_cnt: got %0d expected 2", rdOutstanding); else passCount++;
        clearInputs();
    endtask

    task automatic test_flush_priority();
        doReset();
        dcFlushing = 1'b1; req = 4'b1001; reqIsWrite = 4'b1000; memReqAck = 1'b1;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b1000) $display("[TB] FAIL flush_first: got %b expected 1000", grant); else passCount++;
        @(negedge clk); req = 4'b0001; #1;
        checkCount++; if (memValid !== 1'b0) $display("[TB] FAIL flush_gap: got %b expected 0", memValid); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b0001) $display("[TB] FAIL flush_second: got %b expected 0001", grant); else passCount++;
        clearInputs();
    endtask

    task automatic test_counter_edges();
        doReset();
        rdRspValid = 1'b1;
        @(negedge clk); rdRspValid = 1'b0; #1;
        checkCount++; if (rdOutstanding !== 2'd0) $display("[TB] FAIL cnt_underflow: got %0d expected 0", rdOutstanding); else passCount++;
        req = 4'b0001; memReqAck = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checkCount++; if (rdOutstanding !== 2'd1) $display("[TB] FAIL cnt_one: got %0d expected 1", rdOutstanding); else passCount++;
        @(negedge clk); rdRspValid = 1'b1; #1;
        checkCount++; if (grant !== 4'b0001) $display("[TB] FAIL cnt_grant: got %b expected 0001", grant); else passCount++;
        @(negedge clk); rdRspValid = 1'b0; req = '0; #1;
        checkCount++; if (rdOutstanding !== 2'd1) $display("[TB] FAIL cnt_simul: got %0d expected 1", rdOutstanding); else passCount++;
        clearInputs();
    endtask

    task automatic test_reset_mid_hold();
        doReset();
        req = 4'b0001; memReqAck = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); req = 4'b0010; reqIsWrite = 4'b0010; memReqAck = 1'b0; #1;
        @(negedge clk); #1;
        checkCount++; if (memValid !== 1'b1 || rdOutstanding !== 2'd1) $display("[TB] FAIL rmh_hold: got v=%b cnt=%0d expected v=1 cnt=1", memValid, rdOutstanding); else passCount++;
        @(negedge clk); rst = 1'b1; memReqAck = 1'b1; #1;
        checkCount++; if (grant !== 4'b0000) $display("[TB] FAIL rmh_nogrant: got %b expected 0000", grant); else passCount++;
        @(negedge clk); rst = 1'b0; req = 4'b1111; reqIsWrite = 4'b0000; #1;
        checkCount++; if (memValid !== 1'b0 || grant !== 4'b0000 || rdOutstanding !== 2'd0)
            $display("[TB] FAIL rmh_after: got v=%b g=%b cnt=%0d expected v=0 g=0000 cnt=0", memValid, grant, rdOutstanding);
        else passCount++;
        @(negedge clk); #1;
        checkCount++; if (grant !== 4'b0001) $display("[TB] FAIL rmh_ptr: got %b expected 0001", grant); else passCount++;
        clearInputs();
    endtask

    function automatic int pickWinner(input logic [3:0] r, input logic [3:0] w, input bit full,
                                      input bit flush, input int ptr);
        int firstAny = -1;
        int firstWrite = -1;
        for (int k = 0; k < NR; k++) begin
            int i = (ptr + k) % NR;
            if (r[i] && (w[i] || !full)) begin
                if (firstAny < 0) firstAny = i;
                if (w[i] && firstWrite < 0) firstWrite = i;
            end
        end
        return (flush && firstWrite >= 0) ? firstWrite : firstAny;
    endfunction

    task automatic test_random();
        bit          pend[NR];
        bit          pw[NR];
        logic [31:0] pa[NR];
        logic [127:0] pd[NR];
        bit          mBusy = 0;
        int          mSel = 0;
        bit          mWE = 0;
        logic [31:0] mAddr = '0;
        logic [127:0] mData = '0;
        int          mPtr = 0;
        int          mRd = 0;
        int          win;
        int          newRd;
        logic [3:0]  expG;
        doReset();
        for (int i = 0; i < NR; i++) pend[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c > 0) @(negedge clk);
            rst = ($urandom % 150 == 0);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom % 4 == 0)) begin
                    pend[i] = 1; pw[i] = $urandom % 2; pa[i] = $urandom;
                    pd[i] = {$urandom, $urandom, $urandom, $urandom};
                end
                req[i] = pend[i]; reqIsWrite[i] = pw[i];
                reqAddr[i*AW +: AW] = pa[i]; reqData[i*LW +: LW] = pd[i];
            end
            dcFlushing = ($urandom % 3 == 0);
            memReqAck = ($urandom % 3 != 0);
            memSerial = 4'($urandom); memWSerial = 4'($urandom);
            rdRspValid = ($urandom % 3 == 0);
            #1;
            expG = (mBusy && memReqAck && !rst) ? (4'b0001 << mSel) : 4'b0000;
            checkCount++; if (memValid !== mBusy) $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", c, memValid, mBusy); else passCount++;
            checkCount++; if (grant !== expG) $display("[TB] FAIL rnd_grant[%0d]: got %b expected %b", c, grant, expG); else passCount++;
            checkCount++; if (rdOutstanding !== 2'(mRd) || rdFull !== (mRd == MX))
                $display("[TB] FAIL rnd_cnt[%0d]: got %0d/%b expected %0d/%b", c, rdOutstanding, rdFull, mRd, mRd == MX);
            else passCount++;
            if (mBusy) begin
                checkCount++; if (memWE !== mWE || memAddr !== mAddr || memData !== mData)
                    $display("[TB] FAIL rnd_req[%0d]: got we=%b a=%h expected we=%b a=%h", c, memWE, memAddr, mWE, mAddr);
                else passCount++;
            end
            if (expG != 0) begin
                checkCount++; if (grantSerial !== (mWE ? memWSerial : memSerial))
                    $display("[TB] FAIL rnd_serial[%0d]: got %h expected %h", c, grantSerial, mWE ? memWSerial : memSerial);
                else passCount++;
            end
            if (rst) begin
                mBusy = 0; mPtr = 0; mRd = 0;
            end else begin
                newRd = mRd + ((mBusy && memReqAck && !mWE) ? 1 : 0) - (rdRspValid ? 1 : 0);
                if (newRd < 0) newRd = 0;
                if (mBusy) begin
                    if (memReqAck) begin
                        pend[mSel] = 0; mPtr = (mSel + 1) % NR; mBusy = 0;
                    end
                end else begin
                    win = pickWinner(req, reqIsWrite, mRd == MX, dcFlushing, mPtr);
                    if (win >= 0) begin
                        mBusy = 1; mSel = win; mWE = pw[win]; mAddr = pa[win]; mData = pd[win];
                    end
                end
                mRd = newRd;
            end
        end
        rst = 1'b0;
        clearInputs();
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_round_robin();
        test_hold_stall();
        test_read_throttle();
        test_flush_priority();
        test_counter_edges();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
